// File: rtl/usb_rx_ctrl.sv
// rtl/usb_rx_ctrl.sv - USB full-speed receive control FSM
//
// Sequences a USB full-speed receive: waits for the first line edge,
// checks the SYNC byte, strobes one FIFO write per data byte, separates
// clean from malformed end-of-packet, and holds a sticky error flag until
// the next packet starts.
//
// Ports:
//   clk            system clock, rising edge
//   n_rst          synchronous active-low reset
//   d_edge         one-cycle pulse on any D+/D- transition
//   eop            level, high while SE0 is on the line
//   shift_enable   one-cycle pulse at each bit sample point
//   byte_received  one-cycle pulse after 8 bits have been shifted
//   rcv_data       RX shift register contents, valid with byte_received
//   rcving         high while a packet is being received
//   w_enable       one-cycle FIFO write strobe
//   r_error        sticky receive error flag
//   byte_count     data bytes written in the current packet
module usb_rx_ctrl #(
  parameter logic [7:0] SYNC_BYTE = 8'h80,
  parameter int         MAX_BYTES = 64
) (
  input  logic       clk,
  input  logic       n_rst,
  input  logic       d_edge,
  input  logic       eop,
  input  logic       shift_enable,
  input  logic       byte_received,
  input  logic [7:0] rcv_data,
  output logic       rcving,
  output logic       w_enable,
  output logic       r_error,
  output logic [6:0] byte_count
);

  localparam logic [6:0] MAX_CNT = 7'(MAX_BYTES);

  typedef enum logic [2:0] {
    IDLE,
    SYNC,
    DATA,
    STORE,
    EOP_WAIT,
    ERR_EOP,
    ERR_IDLE
  } state_t;

  state_t     state;
  state_t     next_state;
  logic [2:0] bit_cnt;
  logic       eop_seen;
  logic       enter_sync;
  logic       eop_sample;

  assign eop_sample = eop && shift_enable;
  assign enter_sync = (next_state == SYNC) && (state != SYNC);

  always_ff @(posedge clk) begin
    if (!n_rst) begin
      state      <= IDLE;
      bit_cnt    <= 3'd0;
      byte_count <= 7'd0;
      eop_seen   <= 1'b0;
    end else begin
      state <= next_state;

      if (enter_sync || byte_received)
        bit_cnt <= 3'd0;
      else if (shift_enable)
        bit_cnt <= bit_cnt + 3'd1;

      if (enter_sync)
        byte_count <= 7'd0;
      else if (state == STORE && byte_count != MAX_CNT)
        byte_count <= byte_count + 7'd1;

      // An errored packet is only considered finished once SE0 has been
      // observed; edges before that are still part of the bad packet.
      eop_seen <= (state == ERR_EOP) && (eop_seen || eop);
    end
  end

  always_comb begin
    next_state = state;
    case (state)
      IDLE: begin
        if (d_edge)
          next_state = SYNC;
      end
      SYNC: begin
        if (eop_sample)
          next_state = ERR_EOP;
        else if (byte_received)
          next_state = (rcv_data == SYNC_BYTE) ? DATA : ERR_EOP;
      end
      DATA: begin
        // EOP at a byte boundary is a clean end; mid-byte it is a
        // truncated byte. Either way it wins over a coincident byte.
        if (eop_sample)
          next_state = (bit_cnt == 3'd0) ? EOP_WAIT : ERR_EOP;
        else if (byte_received)
          next_state = (byte_count == MAX_CNT) ? ERR_EOP : STORE;
      end
      STORE: begin
        next_state = DATA;
      end
      EOP_WAIT: begin
        if (d_edge)
          next_state = IDLE;
      end
      ERR_EOP: begin
        if (d_edge && (eop_seen || eop))
          next_state = ERR_IDLE;
      end
      ERR_IDLE: begin
        if (d_edge)
          next_state = SYNC;
      end
      default: begin
        next_state = IDLE;
      end
    endcase
  end

  always_comb begin
    rcving   = 1'b0;
    w_enable = 1'b0;
    r_error  = 1'b0;
    case (state)
      SYNC, DATA, EOP_WAIT: rcving = 1'b1;
      STORE: begin
        rcving   = 1'b1;
        w_enable = 1'b1;
      end
      ERR_EOP, ERR_IDLE: r_error = 1'b1;
      default: begin
        rcving = 1'b0;
      end
    endcase
  end

endmodule

// File: tb/tb_usb_rx_ctrl.sv
// tb/tb_usb_rx_ctrl.sv - self-checking bench for usb_rx_ctrl
module tb_usb_rx_ctrl;

  localparam int MAXB = 4;

  logic       clk = 1'b0;
  logic       n_rst;
  logic       d_edge;
  logic       eop;
  logic       shift_enable;
  logic       byte_received;
  logic [7:0] rcv_data;
  logic       rcving;
  logic       w_enable;
  logic       r_error;
  logic [6:0] byte_count;

  int errors = 0;
  int checks = 0;

  logic [7:0] wq[$];
  logic [7:0] exp_q[$];
  logic [7:0] fixed_q[$];

  usb_rx_ctrl #(.SYNC_BYTE(8'h80), .MAX_BYTES(MAXB)) dut (
    .clk(clk),
    .n_rst(n_rst),
    .d_edge(d_edge),
    .eop(eop),
    .shift_enable(shift_enable),
    .byte_received(byte_received),
    .rcv_data(rcv_data),
    .rcving(rcving),
    .w_enable(w_enable),
    .r_error(r_error),
    .byte_count(byte_count)
  );

  always #5 clk = ~clk;

  always @(posedge clk)
    if (w_enable) wq.push_back(rcv_data);

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic shifts(input int m);
    for (int i = 0; i < m; i++) begin
      repeat (3) tick();
      shift_enable = 1'b1;
      tick();
      shift_enable = 1'b0;
    end
  endtask

  task automatic raw_byte(input logic [7:0] b);
    shifts(8);
    rcv_data      = b;
    byte_received = 1'b1;
    tick();
    byte_received = 1'b0;
  endtask

  // Packet-level model: a byte is written iff SYNC matched, no error has
  // occurred yet and fewer than MAXB bytes have been written; a further
  // byte beyond MAXB is an overflow error. A mid-byte EOP (k != 0) is an
  // error; an EOP coinciding with a byte (simul) ends cleanly, byte dropped.
  task automatic packet(input logic [7:0] sync, input int n, input int k, input bit simul);
    bit         err;
    bit         w;
    int         cnt;
    int         nfull;
    logic [7:0] b;
    err = 1'b0;
    cnt = 0;
    wq.delete();
    exp_q.delete();
    d_edge = 1'b1;
    tick();
    d_edge = 1'b0;
    chk("start_rcving", 32'(rcving), 32'd1);
    chk("start_rerr", 32'(r_error), 32'd0);
    chk("start_cnt", 32'(byte_count), 32'd0);

    raw_byte(sync);
    err = (sync != 8'h80);
    chk("sync_w", 32'(w_enable), 32'd0);
    chk("sync_rerr", 32'(r_error), 32'(err));
    chk("sync_rcving", 32'(rcving), 32'(!err));

    nfull = simul ? n - 1 : n;
    for (int i = 0; i < nfull; i++) begin
      b = (fixed_q.size() > 0) ? fixed_q.pop_front() : 8'($urandom);
      raw_byte(b);
      w = !err && (cnt < MAXB);
      if (!err && cnt == MAXB) err = 1'b1;
      chk("data_w", 32'(w_enable), 32'(w));
      chk("data_rerr", 32'(r_error), 32'(err));
      if (w) begin
        exp_q.push_back(b);
        cnt++;
      end
      tick();
      chk("w_one_cycle", 32'(w_enable), 32'd0);
      chk("byte_count", 32'(byte_count), 32'(cnt));
    end

    if (simul) begin
      shifts(8);
      rcv_data      = 8'($urandom);
      eop           = 1'b1;
      shift_enable  = 1'b1;
      byte_received = 1'b1;
      tick();
      shift_enable  = 1'b0;
      byte_received = 1'b0;
    end else begin
      shifts(k);
      eop = 1'b1;
      repeat (3) tick();
      shift_enable = 1'b1;
      tick();
      shift_enable = 1'b0;
      if (k != 0) err = 1'b1;
    end
    chk("eop_w", 32'(w_enable), 32'd0);
    chk("eop_rerr", 32'(r_error), 32'(err));
    chk("eop_rcving", 32'(rcving), 32'(!err));

    repeat (4) tick();
    chk("se0_w", 32'(w_enable), 32'd0);
    eop    = 1'b0;
    d_edge = 1'b1;
    tick();
    d_edge = 1'b0;
    chk("end_rcving", 32'(rcving), 32'd0);
    chk("end_rerr", 32'(r_error), 32'(err));
    chk("end_cnt", 32'(byte_count), 32'(cnt));
    chk("nwrites", 32'(wq.size()), 32'(exp_q.size()));
    for (int i = 0; i < exp_q.size() && i < wq.size(); i++)
      chk("wdata", 32'(wq[i]), 32'(exp_q[i]));
  endtask

  initial begin
    n_rst         = 1'b0;
    d_edge        = 1'b0;
    eop           = 1'b0;
    shift_enable  = 1'b0;
    byte_received = 1'b0;
    rcv_data      = 8'h00;
    repeat (2) tick();
    chk("rst_rcving", 32'(rcving), 32'd0);
    chk("rst_w", 32'(w_enable), 32'd0);
    chk("rst_rerr", 32'(r_error), 32'd0);
    chk("rst_cnt", 32'(byte_count), 32'd0);
    n_rst = 1'b1;
    tick();
    chk("idle_rcving", 32'(rcving), 32'd0);

    fixed_q = '{8'hA5, 8'h3C};
    packet(8'h80, 2, 0, 1'b0);
    packet(8'h81, 2, 0, 1'b0);
    packet(8'h80, 1, 3, 1'b0);
    packet(8'h80, 5, 0, 1'b0);
    packet(8'h80, 0, 0, 1'b0);

    // Reset in the middle of a packet: no later byte may be written.
    d_edge = 1'b1;
    tick();
    d_edge = 1'b0;
    raw_byte(8'h80);
    raw_byte(8'h11);
    tick();
    raw_byte(8'h22);
    tick();
    n_rst = 1'b0;
    tick();
    n_rst = 1'b1;
    chk("mid_rst_rcving", 32'(rcving), 32'd0);
    chk("mid_rst_w", 32'(w_enable), 32'd0);
    chk("mid_rst_rerr", 32'(r_error), 32'd0);
    chk("mid_rst_cnt", 32'(byte_count), 32'd0);
    wq.delete();
    raw_byte(8'h33);
    tick();
    raw_byte(8'h44);
    tick();
    chk("post_rst_writes", 32'(wq.size()), 32'd0);
    chk("post_rst_rcving", 32'(rcving), 32'd0);

    packet(8'h80, 3, 0, 1'b1);
    packet(8'h80, 5, 0, 1'b1);

    for (int p = 0; p < 20; p++) begin
      logic [7:0] s;
      int         n;
      int         k;
      bit         sm;
      s  = ($urandom_range(0, 4) == 0) ? 8'($urandom) : 8'h80;
      n  = $urandom_range(0, 6);
      k  = ($urandom_range(0, 2) == 0) ? $urandom_range(1, 7) : 0;
      sm = (n > 0) && ($urandom_range(0, 4) == 0);
      packet(s, n, k, sm);
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/usb_rx_ctrl.md
# usb_rx_ctrl

Receive control unit for the USB full-speed receiver. Sequences the bit/byte timer and RX shift register: starts reception on the first line edge, checks the SYNC byte, issues one FIFO write strobe per received byte, detects clean vs. malformed end-of-packet, and holds a sticky receive-error flag until the next packet starts. Sits between the edge/EOP detectors, the timer, the shift register and the RX FIFO.

## Interface
- SYNC_BYTE, 8'h80, expected first byte after shifting (LSB-first SYNC pattern).
- MAX_BYTES, 64, maximum data bytes per packet (SYNC excluded); range 1..127.
- clk  in  1  system clock; all logic on rising edge.
- n_rst  in  1  reset, synchronous, active-low; sampled on rising edge of clk.
- d_edge  in  1  one-cycle pulse on any D+/D- transition.
- eop  in  1  level, high while SE0 (end-of-packet) is present on the line.
- shift_enable  in  1  one-cycle pulse at each bit sample point, from the timer.
- byte_received  in  1  one-cycle pulse when 8 bits have been shifted, from the timer.
- rcv_data  in  8  parallel contents of the RX shift register; valid on the cycle byte_received is high.
- rcving  out  1  high while a packet is being received; drives the timer's enable/clear.
- w_enable  out  1  one-cycle FIFO write strobe; rcv_data is the byte to write.
- r_error  out  1  sticky error flag.
- byte_count  out  7  data bytes written in the current packet.

## Operation
- States: IDLE, SYNC, DATA, STORE, EOP_WAIT, ERR_EOP, ERR_IDLE.
- Internal bit_cnt (3 bits): cleared on entry to SYNC and on byte_received; incremented on each shift_enable otherwise; wraps 7->0.
- IDLE: rcving=0. d_edge -> SYNC; clears r_error and byte_count.
- SYNC: rcving=1. byte_received with rcv_data==SYNC_BYTE -> DATA. byte_received with mismatch -> ERR_EOP. eop&&shift_enable before byte_received -> ERR_EOP.
- DATA: rcving=1. byte_received -> STORE. eop&&shift_enable: bit_cnt==0 -> EOP_WAIT (clean); bit_cnt!=0 -> ERR_EOP (partial byte).
- STORE: one cycle; w_enable=1, byte_count+1. If new byte_count==MAX_BYTES and line not at EOP the next byte_received in DATA -> ERR_EOP (overflow); byte is not written. Otherwise -> DATA.
- EOP_WAIT: rcving=1. d_edge (SE0->J) -> IDLE.
- ERR_EOP: rcving=0, r_error=1. eop high then d_edge -> ERR_IDLE. d_edge while eop low ignored.
- ERR_IDLE: rcving=0, r_error=1. d_edge -> SYNC, r_error cleared, byte_count cleared.
- Priority within a cycle: eop&&shift_enable over byte_received in DATA and SYNC; reset over everything.
- byte_count saturates at MAX_BYTES; never wraps.

## Timing
- Reset (n_rst low at a clk edge): state IDLE, rcving=0, w_enable=0, r_error=0, byte_count=0, bit_cnt=0. Reset mid-packet aborts with no further w_enable.
- All outputs are registered/Moore, derived from state; change one cycle after the causing input pulse.
- d_edge in IDLE at cycle N -> rcving=1 at N+1.
- byte_received in DATA at cycle N -> w_enable=1 for exactly cycle N+1, byte_count increments at N+2 visible value; rcv_data must stay stable through N+1 (guaranteed: next shift ≥4 cycles later).
- w_enable never asserts in SYNC, ERR_EOP, ERR_IDLE or IDLE; at most one strobe per byte_received.
- r_error rises one cycle after the detecting event; falls one cycle after the next-packet d_edge from ERR_IDLE.
- Back-to-back: d_edge in the cycle immediately after EOP_WAIT->IDLE starts a new packet normally.

## Test plan
- Clean packet: SYNC 8'h80 + bytes 8'hA5, 8'h3C, then EOP at bit_cnt 0 -> exactly two w_enable pulses with rcv_data A5, 3C; byte_count=2; r_error=0; IDLE after final d_edge.
- Bad SYNC: first byte 8'h81 -> no w_enable, r_error=1 and rcving=0 next cycle; stays set until next packet's first d_edge clears it.
- Partial byte EOP: SYNC, 1 byte, 3 more bits then eop with shift_enable -> one w_enable, r_error=1, ERR_EOP then ERR_IDLE after SE0->J edge.
- Overflow: MAX_BYTES=4, send 5 data bytes -> exactly 4 w_enable, byte_count=4, r_error=1.
- Reset mid-DATA: n_rst low for one edge after 2 bytes -> all outputs 0 next cycle, later byte_received pulses produce no w_enable until new d_edge.
- Simultaneous eop&&shift_enable and byte_received in DATA at bit_cnt 0 -> treated as clean EOP, no extra w_enable.
